// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skews fetched BRAM words into a diagonal wavefront for a systolic array edge.
// Lane k is delayed k+1 cycles; a tile is TILE_ROWS accepted words followed by a drain of the wavefront.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_BITS   = 8,
  parameter int TILE_ROWS  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic [DATA_WIDTH-1:0]          skew_data,
  output logic [DATA_WIDTH/NUM_BITS-1:0] skew_valid,
  output logic                           busy,
  output logic                           tile_done,
  output logic                           overflow
);

  localparam int LANES   = DATA_WIDTH / NUM_BITS;
  localparam int ROW_W   = $clog2(TILE_ROWS + 1);
  localparam int DRAIN_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t             state;
  logic [ROW_W-1:0]   row_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept;

  assign accept = (state == STREAM) && in_valid;

  // Drain runs until lane LANES-1 has emitted the last accepted word; tile_done marks the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= STREAM;
            busy     <= 1'b1;
            row_cnt  <= '0;
            overflow <= 1'b0;
          end else if (in_valid) begin
            overflow <= 1'b1;
          end
        end
        STREAM: begin
          if (in_valid) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == ROW_W'(TILE_ROWS - 1)) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (in_valid) begin
            overflow <= 1'b1;
          end
          if (drain_cnt == DRAIN_W'(LANES - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            tile_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [NUM_BITS-1:0] dly [0:k];
    logic [k:0]          vld;

    // Shifts unconditionally so bubbles travel with the data instead of stalling the wavefront.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= k; j++) begin
          dly[j] <= '0;
        end
        vld <= '0;
      end else begin
        dly[0] <= accept ? in_data[k*NUM_BITS +: NUM_BITS] : '0;
        vld[0] <= accept;
        for (int j = 1; j <= k; j++) begin
          dly[j] <= dly[j-1];
          vld[j] <= vld[j-1];
        end
      end
    end

    assign skew_data[k*NUM_BITS +: NUM_BITS] = dly[k];
    assign skew_valid[k]                     = vld[k];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - self-checking bench for systolic_skew_feeder (default and TILE_ROWS=1 instances).
module tb_systolic_skew_feeder;
  localparam int DW   = 256;
  localparam int NB   = 8;
  localparam int LN   = DW / NB;
  localparam int TR   = 32;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          s0 = 1'b0, v0 = 1'b0;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] sd0;
  logic [LN-1:0] sv0;
  logic          b0, td0, of0;

  logic          s1 = 1'b0, v1 = 1'b0;
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] sd1;
  logic [LN-1:0] sv1;
  logic          b1, td1, of1;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .NUM_BITS(NB), .TILE_ROWS(TR)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .in_valid(v0), .in_data(d0),
    .skew_data(sd0), .skew_valid(sv0), .busy(b0), .tile_done(td0), .overflow(of0)
  );

  systolic_skew_feeder #(.DATA_WIDTH(DW), .NUM_BITS(NB), .TILE_ROWS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .in_valid(v1), .in_data(d1),
    .skew_data(sd1), .skew_valid(sv1), .busy(b1), .tile_done(td1), .overflow(of1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a log of which cycles delivered an accepted word, plus tile bookkeeping.
  int            t;
  int            base;
  bit            in_tile;
  int            n_acc;
  int            done_cyc;
  bit            ovf;
  logic [DW-1:0] hd [MAXC];
  bit            ha [MAXC];

  typedef struct {
    logic s;
    logic v;
    int   reps;
    logic eb;
    logic eo;
    logic ed;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [DW-1:0] basic_word(input int row);
    logic [DW-1:0] w;
    for (int k = 0; k < LN; k++) w[k*NB +: NB] = 8'(row * 2 + k + 2);
    return w;
  endfunction

  task automatic check_zero(input string tag);
    chk($sformatf("%s dut0 data", tag), sd0, '0);
    chk($sformatf("%s dut0 valid", tag), DW'(sv0), '0);
    chk($sformatf("%s dut0 ctl", tag), DW'({b0, td0, of0}), '0);
    chk($sformatf("%s dut1 data", tag), sd1, '0);
    chk($sformatf("%s dut1 valid", tag), DW'(sv1), '0);
    chk($sformatf("%s dut1 ctl", tag), DW'({b1, td1, of1}), '0);
  endtask

  // Called at a falling edge: check this cycle's outputs, then apply inputs and advance the model.
  task automatic step0(input logic s, input logic v, input logic [DW-1:0] d);
    logic [DW-1:0] ed;
    logic [LN-1:0] ev;
    int            src;
    bit            acc;
    if (t >= MAXC) begin
      $display("FAIL cycle budget: got %0d want <%0d", t, MAXC);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "cycle budget exceeded");
    end
    ed = '0;
    ev = '0;
    for (int k = 0; k < LN; k++) begin
      src = t - 1 - k;
      if (src >= base && ha[src]) begin
        ed[k*NB +: NB] = hd[src][k*NB +: NB];
        ev[k] = 1'b1;
      end
    end
    chk($sformatf("data@%0d", t), sd0, ed);
    chk($sformatf("valid@%0d", t), DW'(sv0), DW'(ev));
    chk($sformatf("busy@%0d", t), DW'(b0), DW'(in_tile));
    chk($sformatf("done@%0d", t), DW'(td0), DW'(t == done_cyc));
    chk($sformatf("ovf@%0d", t), DW'(of0), DW'(ovf));

    s0 = s;
    v0 = v;
    d0 = d;
    acc = in_tile && (n_acc < TR) && v;
    ha[t] = acc;
    hd[t] = d;
    if (acc) begin
      n_acc++;
      if (n_acc == TR) done_cyc = t + LN + 1;
    end
    if (!in_tile) begin
      if (s) begin
        in_tile  = 1'b1;
        n_acc    = 0;
        ovf      = 1'b0;
        done_cyc = -1;
      end else if (v) begin
        ovf = 1'b1;
      end
    end else begin
      if (v && !acc) ovf = 1'b1;
      if (n_acc == TR && t + 1 == done_cyc) in_tile = 1'b0;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    s0 = 1'b0; v0 = 1'b0; s1 = 1'b0; v1 = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero($sformatf("async reset@%0d", t));
    @(negedge clk);
    rst_n    = 1'b1;
    in_tile  = 1'b0;
    n_acc    = 0;
    ovf      = 1'b0;
    done_cyc = -1;
    t++;
    base = t;
  endtask

  task automatic run_tile(input int words);
    step0(1'b1, 1'b0, '0);
    for (int r = 0; r < words; r++) step0(1'b0, 1'b1, rand_word());
  endtask

  task automatic idle0(input int n);
    for (int i = 0; i < n; i++) step0(1'b0, 1'b0, rand_word());
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] ew;
    int            n;
    int            i;

    tbl[0]  = '{s:1'b0, v:1'b1, reps:3,  eb:1'b0, eo:1'b1, ed:1'b0};
    tbl[1]  = '{s:1'b1, v:1'b1, reps:1,  eb:1'b1, eo:1'b0, ed:1'b0};
    tbl[2]  = '{s:1'b0, v:1'b0, reps:2,  eb:1'b1, eo:1'b0, ed:1'b0};
    tbl[3]  = '{s:1'b0, v:1'b1, reps:1,  eb:1'b1, eo:1'b0, ed:1'b0};
    tbl[4]  = '{s:1'b1, v:1'b0, reps:1,  eb:1'b1, eo:1'b0, ed:1'b0};
    tbl[5]  = '{s:1'b0, v:1'b1, reps:1,  eb:1'b1, eo:1'b1, ed:1'b0};
    tbl[6]  = '{s:1'b0, v:1'b0, reps:29, eb:1'b1, eo:1'b1, ed:1'b0};
    tbl[7]  = '{s:1'b0, v:1'b0, reps:1,  eb:1'b0, eo:1'b1, ed:1'b1};
    tbl[8]  = '{s:1'b1, v:1'b0, reps:1,  eb:1'b1, eo:1'b0, ed:1'b0};
    tbl[9]  = '{s:1'b0, v:1'b1, reps:1,  eb:1'b1, eo:1'b0, ed:1'b0};
    tbl[10] = '{s:1'b0, v:1'b0, reps:31, eb:1'b1, eo:1'b0, ed:1'b0};
    tbl[11] = '{s:1'b0, v:1'b0, reps:1,  eb:1'b0, eo:1'b0, ed:1'b1};
    tbl[12] = '{s:1'b0, v:1'b0, reps:2,  eb:1'b0, eo:1'b0, ed:1'b0};

    t = 0; base = 0; in_tile = 1'b0; n_acc = 0; done_cyc = -1; ovf = 1'b0;

    @(negedge clk);
    check_zero("reset state");
    rst_n = 1'b1;
    @(negedge clk);

    // TILE_ROWS=1 instance: control sequencing from the vector table.
    for (int r = 0; r < 13; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        s1 = tbl[r].s;
        v1 = tbl[r].v;
        d1 = rand_word();
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("tbl%0d.%0d busy", r, k), DW'(b1), DW'(tbl[r].eb));
        chk($sformatf("tbl%0d.%0d ovf", r, k), DW'(of1), DW'(tbl[r].eo));
        chk($sformatf("tbl%0d.%0d done", r, k), DW'(td1), DW'(tbl[r].ed));
      end
    end
    s1 = 1'b0; v1 = 1'b0;

    // TILE_ROWS=1 instance: one word forms a full diagonal, done 33 cycles after the accept.
    s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0; v1 = 1'b1; w = rand_word(); d1 = w;
    @(negedge clk);
    v1 = 1'b0; d1 = '0;
    for (int j = 1; j <= LN; j++) begin
      ew = '0;
      ew[(j-1)*NB +: NB] = w[(j-1)*NB +: NB];
      chk($sformatf("diag%0d valid", j), DW'(sv1), DW'(1) << (j - 1));
      chk($sformatf("diag%0d data", j), sd1, ew);
      chk($sformatf("diag%0d done", j), DW'(td1), '0);
      @(negedge clk);
    end
    chk("diag tile_done", DW'(td1), DW'(1));
    chk("diag busy after", DW'(b1), '0);
    @(negedge clk);
    chk("diag done pulse width", DW'(td1), '0);

    do_reset();

    // Basic tile with the documented lane pattern.
    step0(1'b1, 1'b0, '0);
    for (int r = 0; r < TR; r++) step0(1'b0, 1'b1, basic_word(r));
    idle0(40);

    // Bubbles: 1,0,1 valid pattern until a full tile is accepted.
    step0(1'b1, 1'b0, '0);
    n = 0; i = 0;
    while (n < TR) begin
      if (i % 3 != 1) begin
        step0(1'b0, 1'b1, rand_word());
        n++;
      end else begin
        step0(1'b0, 1'b0, rand_word());
      end
      i++;
    end
    idle0(40);

    // Overflow in IDLE, cleared by start; then a second start during DRAIN is ignored.
    for (int k = 0; k < 3; k++) step0(1'b0, 1'b1, rand_word());
    idle0(2);
    run_tile(TR);
    idle0(3);
    step0(1'b1, 1'b0, '0);
    idle0(40);

    // Start together with in_valid in IDLE.
    step0(1'b1, 1'b1, rand_word());
    for (int r = 0; r < TR; r++) step0(1'b0, 1'b1, rand_word());
    idle0(40);

    // Reset mid-tile, then a clean tile.
    run_tile(10);
    do_reset();
    idle0(2);
    run_tile(TR);
    idle0(40);

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      step0(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7), rand_word());
    end
    idle0(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
